// File: rtl/rvfi_pkg.sv
// Shared types and constants for the RVFI commit packer.
// The trace record layout here matches one retired instruction on one RVFI channel.
package rvfi_pkg;

  // Canonical nop (addi x0, x0, 0).
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

  // Fall-through pc increments for full-size and compressed instructions.
  localparam logic [31:0] PC_STEP_32 = 32'd4;
  localparam logic [31:0] PC_STEP_16 = 32'd2;

  // Width of a ROB index.
  // The result is kept at least 1 bit so a single-entry buffer still has a legal index.
  function automatic int rob_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One RVFI record: every per-instruction trace field except valid and order.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } rvfi_rec_t;

endpackage

// File: rtl/rvfi_commit_packer_if.sv
// Bus between the out-of-order core and the RVFI commit packer.
// The core side drives the pipeline events; the packer drives the RVFI records.
interface rvfi_commit_packer_if
  import rvfi_pkg::*;
#(
  parameter int ROB_DEPTH    = 32,
  parameter int COMMIT_WIDTH = 2
);

  localparam int RI = rob_idx_w(ROB_DEPTH);

  // Dispatch, one slot per lane
  logic [COMMIT_WIDTH-1:0]          disp_valid;
  logic [COMMIT_WIDTH-1:0][RI-1:0]  disp_rob_idx;
  logic [COMMIT_WIDTH-1:0][31:0]    disp_pc;
  logic [COMMIT_WIDTH-1:0][31:0]    disp_inst;
  logic [COMMIT_WIDTH-1:0][4:0]     disp_rs1_addr;
  logic [COMMIT_WIDTH-1:0][4:0]     disp_rs2_addr;
  logic [COMMIT_WIDTH-1:0][4:0]     disp_rd_addr;

  // Issue
  logic                             iss_valid;
  logic [RI-1:0]                    iss_rob_idx;
  logic [31:0]                      iss_rs1_rdata;
  logic [31:0]                      iss_rs2_rdata;

  // Writeback
  logic                             wb_valid;
  logic [RI-1:0]                    wb_rob_idx;
  logic [31:0]                      wb_rd_wdata;
  logic [31:0]                      wb_pc_wdata;

  // Memory completion
  logic                             mem_valid;
  logic [RI-1:0]                    mem_rob_idx;
  logic [31:0]                      mem_addr;
  logic [31:0]                      mem_rdata;
  logic [31:0]                      mem_wdata;
  logic [3:0]                       mem_rmask;
  logic [3:0]                       mem_wmask;

  // Retire and squash
  logic [COMMIT_WIDTH-1:0]          commit_valid;
  logic [COMMIT_WIDTH-1:0][RI-1:0]  commit_rob_idx;
  logic                             flush;

  // RVFI records
  logic [COMMIT_WIDTH-1:0]          rvfi_valid;
  logic [COMMIT_WIDTH-1:0][63:0]    rvfi_order;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_inst;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_pc_rdata;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_pc_wdata;
  logic [COMMIT_WIDTH-1:0][4:0]     rvfi_rs1_addr;
  logic [COMMIT_WIDTH-1:0][4:0]     rvfi_rs2_addr;
  logic [COMMIT_WIDTH-1:0][4:0]     rvfi_rd_addr;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_rs1_rdata;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_rs2_rdata;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_rd_wdata;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_mem_addr;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_mem_rdata;
  logic [COMMIT_WIDTH-1:0][31:0]    rvfi_mem_wdata;
  logic [COMMIT_WIDTH-1:0][3:0]     rvfi_mem_rmask;
  logic [COMMIT_WIDTH-1:0][3:0]     rvfi_mem_wmask;
  logic                             protocol_err;

  modport master (
    output disp_valid, disp_rob_idx, disp_pc, disp_inst,
           disp_rs1_addr, disp_rs2_addr, disp_rd_addr,
           iss_valid, iss_rob_idx, iss_rs1_rdata, iss_rs2_rdata,
           wb_valid, wb_rob_idx, wb_rd_wdata, wb_pc_wdata,
           mem_valid, mem_rob_idx, mem_addr, mem_rdata, mem_wdata,
           mem_rmask, mem_wmask,
           commit_valid, commit_rob_idx, flush,
    input  rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
           rvfi_mem_rmask, rvfi_mem_wmask, protocol_err
  );

  modport slave (
    input  disp_valid, disp_rob_idx, disp_pc, disp_inst,
           disp_rs1_addr, disp_rs2_addr, disp_rd_addr,
           iss_valid, iss_rob_idx, iss_rs1_rdata, iss_rs2_rdata,
           wb_valid, wb_rob_idx, wb_rd_wdata, wb_pc_wdata,
           mem_valid, mem_rob_idx, mem_addr, mem_rdata, mem_wdata,
           mem_rmask, mem_wmask,
           commit_valid, commit_rob_idx, flush,
    output rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
           rvfi_mem_rmask, rvfi_mem_wmask, protocol_err
  );

endinterface

// File: rtl/rvfi_side_buffer.sv
// ROB-indexed storage of in-flight RVFI records.
// Each pipeline stage writes only the fields it knows about.
// Commit lanes read entries combinationally.
// The per-entry valid bits live here; the record data is deliberately not reset.
module rvfi_side_buffer
  import rvfi_pkg::*;
#(
  parameter int ROB_DEPTH    = 32,
  parameter int COMMIT_WIDTH = 2,
  parameter int RI           = rob_idx_w(ROB_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  // dispatch (already masked by flush in the caller)
  input  logic [COMMIT_WIDTH-1:0]          disp_we_i,
  input  logic [COMMIT_WIDTH-1:0][RI-1:0]  disp_idx_i,
  input  logic [COMMIT_WIDTH-1:0][31:0]    disp_pc_i,
  input  logic [COMMIT_WIDTH-1:0][31:0]    disp_inst_i,
  input  logic [COMMIT_WIDTH-1:0][4:0]     disp_rs1_addr_i,
  input  logic [COMMIT_WIDTH-1:0][4:0]     disp_rs2_addr_i,
  input  logic [COMMIT_WIDTH-1:0][4:0]     disp_rd_addr_i,
  output logic [COMMIT_WIDTH-1:0]          disp_hit_o,
  // issue
  input  logic                             iss_we_i,
  input  logic [RI-1:0]                    iss_idx_i,
  input  logic [31:0]                      iss_rs1_rdata_i,
  input  logic [31:0]                      iss_rs2_rdata_i,
  // writeback
  input  logic                             wb_we_i,
  input  logic [RI-1:0]                    wb_idx_i,
  input  logic [31:0]                      wb_rd_wdata_i,
  input  logic [31:0]                      wb_pc_wdata_i,
  // memory
  input  logic                             mem_we_i,
  input  logic [RI-1:0]                    mem_idx_i,
  input  logic [31:0]                      mem_addr_i,
  input  logic [31:0]                      mem_rdata_i,
  input  logic [31:0]                      mem_wdata_i,
  input  logic [3:0]                       mem_rmask_i,
  input  logic [3:0]                       mem_wmask_i,
  // commit read ports; a set read-enable also retires the entry
  input  logic [COMMIT_WIDTH-1:0]          clr_i,
  input  logic [COMMIT_WIDTH-1:0][RI-1:0]  rd_idx_i,
  output rvfi_rec_t [COMMIT_WIDTH-1:0]     rd_rec_o,
  output logic [COMMIT_WIDTH-1:0]          rd_valid_o
);

  rvfi_rec_t                mem_q [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]     valid_q;
  logic [ROB_DEPTH-1:0]     valid_d;
  rvfi_rec_t [COMMIT_WIDTH-1:0] disp_rec;

  // Build the fresh record a dispatch writes: fall-through next pc, everything else zero.
  always_comb begin
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      disp_rec[l]          = '0;
      disp_rec[l].inst     = disp_inst_i[l];
      disp_rec[l].pc_rdata = disp_pc_i[l];
      disp_rec[l].pc_wdata = disp_pc_i[l] +
                             ((disp_inst_i[l][1:0] == 2'b11) ? PC_STEP_32 : PC_STEP_16);
      disp_rec[l].rs1_addr = disp_rs1_addr_i[l];
      disp_rec[l].rs2_addr = disp_rs2_addr_i[l];
      disp_rec[l].rd_addr  = disp_rd_addr_i[l];
    end
  end

  // Field-granular record storage; dispatch is applied last so a new instruction owns its entry, highest lane winning.
  always_ff @(posedge clk) begin
    if (iss_we_i) begin
      mem_q[iss_idx_i].rs1_rdata <= iss_rs1_rdata_i;
      mem_q[iss_idx_i].rs2_rdata <= iss_rs2_rdata_i;
    end
    if (wb_we_i) begin
      mem_q[wb_idx_i].rd_wdata <= wb_rd_wdata_i;
      mem_q[wb_idx_i].pc_wdata <= wb_pc_wdata_i;
    end
    if (mem_we_i) begin
      mem_q[mem_idx_i].mem_addr  <= mem_addr_i;
      mem_q[mem_idx_i].mem_rdata <= mem_rdata_i;
      mem_q[mem_idx_i].mem_wdata <= mem_wdata_i;
      mem_q[mem_idx_i].mem_rmask <= mem_rmask_i;
      mem_q[mem_idx_i].mem_wmask <= mem_wmask_i;
    end
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      if (disp_we_i[l]) begin
        mem_q[disp_idx_i[l]] <= disp_rec[l];
      end
    end
  end

  // Next valid bits: flush clears everything; otherwise retire, then allocate (allocation wins on a shared index).
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (clr_i[l]) valid_d[rd_idx_i[l]] = 1'b0;
      end
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (disp_we_i[l]) valid_d[disp_idx_i[l]] = 1'b1;
      end
    end
  end

  // Valid-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Commit read ports and dispatch occupancy lookups.
  always_comb begin
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      rd_rec_o[l]   = mem_q[rd_idx_i[l]];
      rd_valid_o[l] = valid_q[rd_idx_i[l]];
      disp_hit_o[l] = valid_q[disp_idx_i[l]];
    end
  end

endmodule

// File: rtl/rvfi_commit_packer.sv
// Producer side of the RVFI commit interface.
// The side buffer collects the trace fields of each in-flight instruction.
// This level forwards same-cycle updates into retiring records, numbers them in order, and registers the output.
// It also watches the core for retire/dispatch protocol violations.
module rvfi_commit_packer
  import rvfi_pkg::*;
#(
  parameter int ROB_DEPTH    = 32,
  parameter int COMMIT_WIDTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  rvfi_commit_packer_if.slave bus
);

  localparam int RI = rob_idx_w(ROB_DEPTH);

  logic [COMMIT_WIDTH-1:0]          disp_we;
  logic [COMMIT_WIDTH-1:0]          disp_hit;
  logic [COMMIT_WIDTH-1:0]          disp_retire;
  rvfi_rec_t [COMMIT_WIDTH-1:0]     rd_rec;
  logic [COMMIT_WIDTH-1:0]          rd_valid;
  rvfi_rec_t [COMMIT_WIDTH-1:0]     rec_bp;

  logic [COMMIT_WIDTH-1:0][63:0]    lane_order;
  logic [63:0]                      order_cnt_q;
  logic [63:0]                      order_cnt_d;
  logic [3:0]                       lane_cnt;

  logic [COMMIT_WIDTH-1:0]          rvfi_valid_q;
  rvfi_rec_t [COMMIT_WIDTH-1:0]     out_rec_q;
  logic [COMMIT_WIDTH-1:0][63:0]    out_order_q;
  logic                             err_q;
  logic                             err_d;

  assign disp_we = bus.disp_valid & ~{COMMIT_WIDTH{bus.flush}};

  rvfi_side_buffer #(
    .ROB_DEPTH   (ROB_DEPTH),
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .RI          (RI)
  ) u_side_buffer (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (bus.flush),
    .disp_we_i      (disp_we),
    .disp_idx_i     (bus.disp_rob_idx),
    .disp_pc_i      (bus.disp_pc),
    .disp_inst_i    (bus.disp_inst),
    .disp_rs1_addr_i(bus.disp_rs1_addr),
    .disp_rs2_addr_i(bus.disp_rs2_addr),
    .disp_rd_addr_i (bus.disp_rd_addr),
    .disp_hit_o     (disp_hit),
    .iss_we_i       (bus.iss_valid),
    .iss_idx_i      (bus.iss_rob_idx),
    .iss_rs1_rdata_i(bus.iss_rs1_rdata),
    .iss_rs2_rdata_i(bus.iss_rs2_rdata),
    .wb_we_i        (bus.wb_valid),
    .wb_idx_i       (bus.wb_rob_idx),
    .wb_rd_wdata_i  (bus.wb_rd_wdata),
    .wb_pc_wdata_i  (bus.wb_pc_wdata),
    .mem_we_i       (bus.mem_valid),
    .mem_idx_i      (bus.mem_rob_idx),
    .mem_addr_i     (bus.mem_addr),
    .mem_rdata_i    (bus.mem_rdata),
    .mem_wdata_i    (bus.mem_wdata),
    .mem_rmask_i    (bus.mem_rmask),
    .mem_wmask_i    (bus.mem_wmask),
    .clr_i          (bus.commit_valid),
    .rd_idx_i       (bus.commit_rob_idx),
    .rd_rec_o       (rd_rec),
    .rd_valid_o     (rd_valid)
  );

  // Retiring record: stored fields, overlaid with same-cycle stage updates, x0 operands/results zeroed.
  always_comb begin
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      rec_bp[l] = rd_rec[l];
      if (bus.iss_valid && (bus.iss_rob_idx == bus.commit_rob_idx[l])) begin
        rec_bp[l].rs1_rdata = bus.iss_rs1_rdata;
        rec_bp[l].rs2_rdata = bus.iss_rs2_rdata;
      end
      if (bus.wb_valid && (bus.wb_rob_idx == bus.commit_rob_idx[l])) begin
        rec_bp[l].rd_wdata = bus.wb_rd_wdata;
        rec_bp[l].pc_wdata = bus.wb_pc_wdata;
      end
      if (bus.mem_valid && (bus.mem_rob_idx == bus.commit_rob_idx[l])) begin
        rec_bp[l].mem_addr  = bus.mem_addr;
        rec_bp[l].mem_rdata = bus.mem_rdata;
        rec_bp[l].mem_wdata = bus.mem_wdata;
        rec_bp[l].mem_rmask = bus.mem_rmask;
        rec_bp[l].mem_wmask = bus.mem_wmask;
      end
      if (rec_bp[l].rs1_addr == 5'd0) rec_bp[l].rs1_rdata = '0;
      if (rec_bp[l].rs2_addr == 5'd0) rec_bp[l].rs2_rdata = '0;
      if (rec_bp[l].rd_addr  == 5'd0) rec_bp[l].rd_wdata  = '0;
    end
  end

  // Order numbers: each lane counts the retiring lanes below it, so gapped patterns still get distinct numbers.
  always_comb begin
    lane_cnt = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      lane_order[l] = order_cnt_q + 64'(lane_cnt);
      if (bus.commit_valid[l]) lane_cnt = lane_cnt + 4'd1;
    end
    order_cnt_d = order_cnt_q + 64'(lane_cnt);
  end

  // Flag dispatch lanes whose target entry is retiring this cycle; reusing that entry is legal.
  always_comb begin
    disp_retire = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
        if (bus.commit_valid[c] && (bus.commit_rob_idx[c] == bus.disp_rob_idx[l])) begin
          disp_retire[l] = 1'b1;
        end
      end
    end
  end

  // Sticky protocol error: gapped commit, retiring an empty entry, or allocating an occupied/duplicated entry.
  always_comb begin
    err_d = err_q;
    for (int l = 1; l < COMMIT_WIDTH; l++) begin
      if (bus.commit_valid[l] && !bus.commit_valid[l-1]) err_d = 1'b1;
    end
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      if (bus.commit_valid[l] && !rd_valid[l]) err_d = 1'b1;
      if (disp_we[l] && disp_hit[l] && !disp_retire[l]) err_d = 1'b1;
      for (int m = 0; m < l; m++) begin
        if (disp_we[l] && disp_we[m] && (bus.disp_rob_idx[l] == bus.disp_rob_idx[m])) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Output and counter registers; record fields of idle lanes hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvfi_valid_q <= '0;
      out_rec_q    <= '0;
      out_order_q  <= '0;
      order_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rvfi_valid_q <= bus.commit_valid;
      order_cnt_q  <= order_cnt_d;
      err_q        <= err_d;
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (bus.commit_valid[l]) begin
          out_rec_q[l]   <= rec_bp[l];
          out_order_q[l] <= lane_order[l];
        end
      end
    end
  end

  // Unpack registered records onto the RVFI channels.
  always_comb begin
    bus.rvfi_valid   = rvfi_valid_q;
    bus.protocol_err = err_q;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      bus.rvfi_order[l]     = out_order_q[l];
      bus.rvfi_inst[l]      = out_rec_q[l].inst;
      bus.rvfi_pc_rdata[l]  = out_rec_q[l].pc_rdata;
      bus.rvfi_pc_wdata[l]  = out_rec_q[l].pc_wdata;
      bus.rvfi_rs1_addr[l]  = out_rec_q[l].rs1_addr;
      bus.rvfi_rs2_addr[l]  = out_rec_q[l].rs2_addr;
      bus.rvfi_rd_addr[l]   = out_rec_q[l].rd_addr;
      bus.rvfi_rs1_rdata[l] = out_rec_q[l].rs1_rdata;
      bus.rvfi_rs2_rdata[l] = out_rec_q[l].rs2_rdata;
      bus.rvfi_rd_wdata[l]  = out_rec_q[l].rd_wdata;
      bus.rvfi_mem_addr[l]  = out_rec_q[l].mem_addr;
      bus.rvfi_mem_rdata[l] = out_rec_q[l].mem_rdata;
      bus.rvfi_mem_wdata[l] = out_rec_q[l].mem_wdata;
      bus.rvfi_mem_rmask[l] = out_rec_q[l].mem_rmask;
      bus.rvfi_mem_wmask[l] = out_rec_q[l].mem_wmask;
    end
  end

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Directed testbench for rvfi_commit_packer.
// Each scenario task drives the core-side bus and checks the registered RVFI records against hand-computed values.
module tb_rvfi_commit_packer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rvfi_commit_packer_if #(.ROB_DEPTH(32), .COMMIT_WIDTH(2)) bus ();

  rvfi_commit_packer #(.ROB_DEPTH(32), .COMMIT_WIDTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic clear_inputs();
    bus.disp_valid = '0; bus.disp_rob_idx = '0; bus.disp_pc = '0; bus.disp_inst = '0;
    bus.disp_rs1_addr = '0; bus.disp_rs2_addr = '0; bus.disp_rd_addr = '0;
    bus.iss_valid = 1'b0; bus.iss_rob_idx = '0; bus.iss_rs1_rdata = '0; bus.iss_rs2_rdata = '0;
    bus.wb_valid = 1'b0; bus.wb_rob_idx = '0; bus.wb_rd_wdata = '0; bus.wb_pc_wdata = '0;
    bus.mem_valid = 1'b0; bus.mem_rob_idx = '0; bus.mem_addr = '0; bus.mem_rdata = '0;
    bus.mem_wdata = '0; bus.mem_rmask = '0; bus.mem_wmask = '0;
    bus.commit_valid = '0; bus.commit_rob_idx = '0; bus.flush = 1'b0;
  endtask

  // One clock; returns 1 time unit after the rising edge so registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input int lane, input logic [4:0] idx, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd);
    bus.disp_valid[lane]    = 1'b1;
    bus.disp_rob_idx[lane]  = idx;
    bus.disp_pc[lane]       = pc;
    bus.disp_inst[lane]     = inst;
    bus.disp_rs1_addr[lane] = rs1;
    bus.disp_rs2_addr[lane] = rs2;
    bus.disp_rd_addr[lane]  = rd;
  endtask

  task automatic set_commit(input int lane, input logic [4:0] idx);
    bus.commit_valid[lane]   = 1'b1;
    bus.commit_rob_idx[lane] = idx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    checks++; if (bus.rvfi_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_valid: got %b want 00", bus.rvfi_valid); end
    checks++; if (bus.protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", bus.protocol_err); end
    checks++; if (bus.rvfi_order[0] !== 64'd0) begin errors++; $display("[TB] FAIL reset_order: got %0h want 0", bus.rvfi_order[0]); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_disp(0, 5'd3, 32'h1000, 32'h00a00093, 5'd0, 5'd0, 5'd1);
    step(); clear_inputs();
    bus.iss_valid = 1'b1; bus.iss_rob_idx = 5'd3; bus.iss_rs1_rdata = 32'h55; bus.iss_rs2_rdata = 32'h66;
    step(); clear_inputs();
    bus.wb_valid = 1'b1; bus.wb_rob_idx = 5'd3; bus.wb_rd_wdata = 32'hA; bus.wb_pc_wdata = 32'h1004;
    step(); clear_inputs();
    set_commit(0, 5'd3);
    step(); clear_inputs();
    checks++; if (bus.rvfi_valid !== 2'b01) begin errors++; $display("[TB] FAIL basic_valid: got %b want 01", bus.rvfi_valid); end
    checks++; if (bus.rvfi_order[0] !== 64'd0) begin errors++; $display("[TB] FAIL basic_order: got %0h want 0", bus.rvfi_order[0]); end
    checks++; if (bus.rvfi_rd_addr[0] !== 5'd1) begin errors++; $display("[TB] FAIL basic_rd_addr: got %0d want 1", bus.rvfi_rd_addr[0]); end
    checks++; if (bus.rvfi_rd_wdata[0] !== 32'hA) begin errors++; $display("[TB] FAIL basic_rd_wdata: got %0h want a", bus.rvfi_rd_wdata[0]); end
    checks++; if (bus.rvfi_pc_wdata[0] !== 32'h1004) begin errors++; $display("[TB] FAIL basic_pc_wdata: got %0h want 1004", bus.rvfi_pc_wdata[0]); end
    checks++; if (bus.rvfi_rs1_rdata[0] !== 32'h0) begin errors++; $display("[TB] FAIL basic_rs1_x0: got %0h want 0", bus.rvfi_rs1_rdata[0]); end
    checks++; if (bus.rvfi_inst[0] !== 32'h00a00093) begin errors++; $display("[TB] FAIL basic_inst: got %0h want a00093", bus.rvfi_inst[0]); end
    step();
    checks++; if (bus.rvfi_valid !== 2'b00) begin errors++; $display("[TB] FAIL basic_idle_valid: got %b want 00", bus.rvfi_valid); end
    checks++; if (bus.rvfi_rd_wdata[0] !== 32'hA) begin errors++; $display("[TB] FAIL basic_hold: got %0h want a", bus.rvfi_rd_wdata[0]); end
  endtask

  task automatic test_compressed();
    set_disp(0, 5'd10, 32'h2002, 32'h00004501, 5'd0, 5'd0, 5'd10);
    step(); clear_inputs();
    set_commit(0, 5'd10);
    step(); clear_inputs();
    checks++; if (bus.rvfi_pc_wdata[0] !== 32'h2004) begin errors++; $display("[TB] FAIL rvc_pc_wdata: got %0h want 2004", bus.rvfi_pc_wdata[0]); end
    checks++; if (bus.rvfi_order[0] !== 64'd1) begin errors++; $display("[TB] FAIL rvc_order: got %0h want 1", bus.rvfi_order[0]); end
    checks++; if (bus.rvfi_rd_wdata[0] !== 32'h0) begin errors++; $display("[TB] FAIL rvc_rd_default: got %0h want 0", bus.rvfi_rd_wdata[0]); end
  endtask

  task automatic test_store_bypass();
    set_disp(0, 5'd6, 32'h3000, 32'h00f51123, 5'd10, 5'd15, 5'd0);
    step(); clear_inputs();
    bus.iss_valid = 1'b1; bus.iss_rob_idx = 5'd6; bus.iss_rs1_rdata = 32'h80000100; bus.iss_rs2_rdata = 32'hBEEF;
    step(); clear_inputs();
    set_commit(0, 5'd6);
    bus.mem_valid = 1'b1; bus.mem_rob_idx = 5'd6; bus.mem_addr = 32'h80000102;
    bus.mem_wdata = 32'hBEEF; bus.mem_wmask = 4'b0011; bus.mem_rdata = 32'h12345678; bus.mem_rmask = 4'b0000;
    step(); clear_inputs();
    checks++; if (bus.rvfi_mem_wmask[0] !== 4'h3) begin errors++; $display("[TB] FAIL st_wmask: got %0h want 3", bus.rvfi_mem_wmask[0]); end
    checks++; if (bus.rvfi_mem_wdata[0] !== 32'hBEEF) begin errors++; $display("[TB] FAIL st_wdata: got %0h want beef", bus.rvfi_mem_wdata[0]); end
    checks++; if (bus.rvfi_mem_addr[0] !== 32'h80000102) begin errors++; $display("[TB] FAIL st_addr: got %0h want 80000102", bus.rvfi_mem_addr[0]); end
    checks++; if (bus.rvfi_mem_rdata[0] !== 32'h12345678) begin errors++; $display("[TB] FAIL st_rdata: got %0h want 12345678", bus.rvfi_mem_rdata[0]); end
    checks++; if (bus.rvfi_rs1_rdata[0] !== 32'h80000100) begin errors++; $display("[TB] FAIL st_rs1: got %0h want 80000100", bus.rvfi_rs1_rdata[0]); end
    checks++; if (bus.rvfi_order[0] !== 64'd2) begin errors++; $display("[TB] FAIL st_order: got %0h want 2", bus.rvfi_order[0]); end
    checks++; if (bus.rvfi_pc_wdata[0] !== 32'h3004) begin errors++; $display("[TB] FAIL st_pc_wdata: got %0h want 3004", bus.rvfi_pc_wdata[0]); end
  endtask

  task automatic test_back_to_back();
    set_disp(0, 5'd20, 32'h4000, 32'h00000013, 5'd0, 5'd0, 5'd0);
    set_disp(1, 5'd21, 32'h4004, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    set_disp(0, 5'd22, 32'h4008, 32'h00000013, 5'd0, 5'd0, 5'd0);
    set_disp(1, 5'd23, 32'h400C, 32'h00000013, 5'd0, 5'd0, 5'd0);
    set_commit(0, 5'd20); set_commit(1, 5'd21);
    step(); clear_inputs();
    checks++; if (bus.rvfi_valid !== 2'b11) begin errors++; $display("[TB] FAIL b2b_valid: got %b want 11", bus.rvfi_valid); end
    checks++; if (bus.rvfi_order[1] !== 64'd4) begin errors++; $display("[TB] FAIL b2b_order1: got %0h want 4", bus.rvfi_order[1]); end
    checks++; if (bus.rvfi_pc_rdata[1] !== 32'h4004) begin errors++; $display("[TB] FAIL b2b_pc1: got %0h want 4004", bus.rvfi_pc_rdata[1]); end
    set_commit(0, 5'd22); set_commit(1, 5'd23);
    step(); clear_inputs();
    checks++; if (bus.rvfi_order[0] !== 64'd5) begin errors++; $display("[TB] FAIL b2b_order2: got %0h want 5", bus.rvfi_order[0]); end
    checks++; if (bus.rvfi_pc_rdata[1] !== 32'h400C) begin errors++; $display("[TB] FAIL b2b_pc3: got %0h want 400c", bus.rvfi_pc_rdata[1]); end
  endtask

  task automatic test_two_lane();
    set_disp(0, 5'd4, 32'h4100, 32'h00208233, 5'd1, 5'd2, 5'd4);
    set_disp(1, 5'd5, 32'h4104, 32'h003282b3, 5'd5, 5'd3, 5'd5);
    step(); clear_inputs();
    set_commit(0, 5'd4); set_commit(1, 5'd5);
    bus.wb_valid = 1'b1; bus.wb_rob_idx = 5'd5; bus.wb_rd_wdata = 32'h1234; bus.wb_pc_wdata = 32'h4108;
    step(); clear_inputs();
    checks++; if (bus.rvfi_order[0] !== 64'd7) begin errors++; $display("[TB] FAIL two_order0: got %0h want 7", bus.rvfi_order[0]); end
    checks++; if (bus.rvfi_order[1] !== 64'd8) begin errors++; $display("[TB] FAIL two_order1: got %0h want 8", bus.rvfi_order[1]); end
    checks++; if (bus.rvfi_rd_wdata[1] !== 32'h1234) begin errors++; $display("[TB] FAIL two_wb_bypass: got %0h want 1234", bus.rvfi_rd_wdata[1]); end
    set_disp(0, 5'd7, 32'h4200, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    set_commit(0, 5'd7);
    set_disp(0, 5'd7, 32'h4300, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    checks++; if (bus.rvfi_order[0] !== 64'd9) begin errors++; $display("[TB] FAIL reuse_order: got %0h want 9", bus.rvfi_order[0]); end
    checks++; if (bus.rvfi_pc_rdata[0] !== 32'h4200) begin errors++; $display("[TB] FAIL reuse_old: got %0h want 4200", bus.rvfi_pc_rdata[0]); end
    set_commit(0, 5'd7);
    step(); clear_inputs();
    checks++; if (bus.rvfi_pc_rdata[0] !== 32'h4300) begin errors++; $display("[TB] FAIL reuse_new: got %0h want 4300", bus.rvfi_pc_rdata[0]); end
    checks++; if (bus.protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL reuse_err: got %b want 0", bus.protocol_err); end
  endtask

  task automatic test_gap();
    set_disp(0, 5'd11, 32'h4400, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    set_commit(1, 5'd11);
    step(); clear_inputs();
    checks++; if (bus.rvfi_valid !== 2'b10) begin errors++; $display("[TB] FAIL gap_valid: got %b want 10", bus.rvfi_valid); end
    checks++; if (bus.rvfi_order[1] !== 64'd11) begin errors++; $display("[TB] FAIL gap_order: got %0h want b", bus.rvfi_order[1]); end
    checks++; if (bus.protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL gap_err: got %b want 1", bus.protocol_err); end
    set_disp(0, 5'd12, 32'h4500, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    set_commit(0, 5'd12);
    step(); clear_inputs();
    checks++; if (bus.rvfi_order[0] !== 64'd12) begin errors++; $display("[TB] FAIL gap_next_order: got %0h want c", bus.rvfi_order[0]); end
    checks++; if (bus.protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL gap_sticky: got %b want 1", bus.protocol_err); end
  endtask

  task automatic test_reset_midstream();
    set_disp(0, 5'd13, 32'h4600, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    set_commit(0, 5'd13);
    step(); clear_inputs();
    checks++; if (bus.rvfi_valid !== 2'b01) begin errors++; $display("[TB] FAIL mid_valid_pre: got %b want 01", bus.rvfi_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rvfi_valid !== 2'b00) begin errors++; $display("[TB] FAIL mid_async_valid: got %b want 00", bus.rvfi_valid); end
    checks++; if (bus.protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_err: got %b want 0", bus.protocol_err); end
    step();
    rst_n = 1'b1;
    set_disp(0, 5'd14, 32'h4700, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    set_commit(0, 5'd14);
    step(); clear_inputs();
    checks++; if (bus.rvfi_order[0] !== 64'd0) begin errors++; $display("[TB] FAIL mid_order0: got %0h want 0", bus.rvfi_order[0]); end
    checks++; if (bus.rvfi_pc_rdata[0] !== 32'h4700) begin errors++; $display("[TB] FAIL mid_pc: got %0h want 4700", bus.rvfi_pc_rdata[0]); end
  endtask

  task automatic test_flush();
    set_disp(0, 5'd8, 32'h4800, 32'h00000013, 5'd0, 5'd0, 5'd0);
    set_disp(1, 5'd9, 32'h4804, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    bus.flush = 1'b1;
    set_commit(0, 5'd8);
    set_disp(1, 5'd15, 32'h4900, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    checks++; if (bus.rvfi_valid !== 2'b01) begin errors++; $display("[TB] FAIL flush_valid: got %b want 01", bus.rvfi_valid); end
    checks++; if (bus.rvfi_order[0] !== 64'd1) begin errors++; $display("[TB] FAIL flush_order: got %0h want 1", bus.rvfi_order[0]); end
    checks++; if (bus.rvfi_pc_rdata[0] !== 32'h4800) begin errors++; $display("[TB] FAIL flush_pc: got %0h want 4800", bus.rvfi_pc_rdata[0]); end
    checks++; if (bus.protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL flush_err_clean: got %b want 0", bus.protocol_err); end
    set_commit(0, 5'd9);
    step(); clear_inputs();
    checks++; if (bus.protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL flush_stale_err: got %b want 1", bus.protocol_err); end
    checks++; if (bus.rvfi_order[0] !== 64'd2) begin errors++; $display("[TB] FAIL flush_stale_order: got %0h want 2", bus.rvfi_order[0]); end
  endtask

  task automatic test_dup_dispatch();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_disp(0, 5'd16, 32'h5000, 32'h00000013, 5'd0, 5'd0, 5'd0);
    set_disp(1, 5'd16, 32'h5100, 32'h00000013, 5'd0, 5'd0, 5'd0);
    step(); clear_inputs();
    checks++; if (bus.protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL dup_err: got %b want 1", bus.protocol_err); end
    set_commit(0, 5'd16);
    step(); clear_inputs();
    checks++; if (bus.rvfi_pc_rdata[0] !== 32'h5100) begin errors++; $display("[TB] FAIL dup_high_lane: got %0h want 5100", bus.rvfi_pc_rdata[0]); end
    checks++; if (bus.rvfi_order[0] !== 64'd0) begin errors++; $display("[TB] FAIL dup_order: got %0h want 0", bus.rvfi_order[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_compressed();
    test_store_bypass();
    test_back_to_back();
    test_two_lane();
    test_gap();
    test_reset_midstream();
    test_flush();
    test_dup_dispatch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
